// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RISC-V M-extension multiply/divide unit.
// One multiply (shift-add) or divide (restoring) step per cycle, XLEN steps per op.
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset
//   start      - request an operation (accepted only in idle with a supported op)
//   op         - funct3: 000 MUL, 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   ReadData1  - operand A (multiplicand / dividend)
//   ReadData2  - operand B (multiplier / divisor)
//   RDIn       - destination register index
//   WriteData  - registered result, held until the next completion
//   RD         - registered destination index paired with WriteData
//   RegWrite   - one-cycle write strobe (suppressed for x0)
//   Busy       - operation in flight; requests refused
module muldiv_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] ReadData1,
  input  logic [XLEN-1:0] ReadData2,
  input  logic [4:0]      RDIn,
  output logic [XLEN-1:0] WriteData,
  output logic [4:0]      RD,
  output logic            RegWrite,
  output logic            Busy
);

  localparam int unsigned CntW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      op_q;
  logic [4:0]      rd_q;
  // acc_q: product (MUL) or partial remainder (divide).
  // a_q:   shifting multiplicand (MUL) or dividend/quotient shift register (divide).
  // b_q:   shifting multiplier (MUL) or divisor magnitude (divide).
  logic [XLEN-1:0] acc_q, a_q, b_q;
  logic            negq_q, negr_q, bzero_q;
  logic [XLEN-1:0] wdata_q;
  logic [4:0]      rd_out_q;
  logic            regwrite_q, busy_q;

  logic            op_ok, signed_in;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] acc_d, a_d, b_d, result;

  always_comb begin
    op_ok     = (op == 3'b000) || op[2];
    // DIV and REM take magnitudes; sign fix-up is applied to the final result.
    signed_in = op[2] & ~op[0];
    a_mag     = (signed_in && ReadData1[XLEN-1]) ? -ReadData1 : ReadData1;
    b_mag     = (signed_in && ReadData2[XLEN-1]) ? -ReadData2 : ReadData2;
  end

  // One iteration step and the result it would produce if it were the last.
  always_comb begin
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    shifted = {acc_q, a_q[XLEN-1]};
    if (op_q == 3'b000) begin
      if (b_q[0]) acc_d = acc_q + a_q;
      a_d = a_q << 1;
      b_d = b_q >> 1;
    end else if (shifted >= {1'b0, b_q}) begin
      acc_d = XLEN'(shifted - {1'b0, b_q});
      a_d   = {a_q[XLEN-2:0], 1'b1};
    end else begin
      acc_d = shifted[XLEN-1:0];
      a_d   = {a_q[XLEN-2:0], 1'b0};
    end

    unique case (op_q)
      3'b100:  result = bzero_q ? '1 : (negq_q ? -a_d : a_d);
      3'b101:  result = a_d;
      3'b110:  result = negr_q ? -acc_d : acc_d;
      3'b111:  result = acc_d;
      default: result = acc_d;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= '0;
      rd_q       <= '0;
      acc_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      negq_q     <= 1'b0;
      negr_q     <= 1'b0;
      bzero_q    <= 1'b0;
      wdata_q    <= '0;
      rd_out_q   <= '0;
      regwrite_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          regwrite_q <= 1'b0;
          if (start && op_ok) begin
            state_q <= StCalc;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            op_q    <= op;
            rd_q    <= RDIn;
            acc_q   <= '0;
            a_q     <= a_mag;
            b_q     <= b_mag;
            negq_q  <= signed_in && (ReadData1[XLEN-1] ^ ReadData2[XLEN-1]);
            negr_q  <= signed_in && ReadData1[XLEN-1];
            bzero_q <= (ReadData2 == '0);
          end
        end
        StCalc: begin
          acc_q <= acc_d;
          a_q   <= a_d;
          b_q   <= b_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(XLEN - 1)) begin
            state_q    <= StDone;
            wdata_q    <= result;
            rd_out_q   <= rd_q;
            regwrite_q <= (rd_q != 5'd0);
          end
        end
        StDone: begin
          state_q    <= StIdle;
          regwrite_q <= 1'b0;
          busy_q     <= 1'b0;
        end
        default: begin
          state_q    <= StIdle;
          regwrite_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign WriteData = wdata_q;
  assign RD        = rd_out_q;
  assign RegWrite  = regwrite_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int unsigned XLEN = 64;
  localparam logic [63:0] MinNeg = 64'h8000_0000_0000_0000;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [2:0]      op = 3'b000;
  logic [XLEN-1:0] ReadData1 = '0;
  logic [XLEN-1:0] ReadData2 = '0;
  logic [4:0]      RDIn = '0;
  logic [XLEN-1:0] WriteData;
  logic [4:0]      RD;
  logic            RegWrite;
  logic            Busy;

  int errors = 0;
  int checks = 0;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2),
    .RDIn      (RDIn),
    .WriteData (WriteData),
    .RD        (RD),
    .RegWrite  (RegWrite),
    .Busy      (Busy)
  );

  always #5 clk = ~clk;

  // Reference: RISC-V M semantics computed with plain arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] f, input logic [63:0] a,
                                             input logic [63:0] b);
    logic [127:0] p;
    case (f)
      3'b000: begin p = {64'd0, a} * {64'd0, b}; return p[63:0]; end
      3'b101: return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
      3'b111: return (b == 0) ? a : a % b;
      3'b100: begin
        if (b == 0) return 64'hFFFF_FFFF_FFFF_FFFF;
        if (a == MinNeg && b == 64'hFFFF_FFFF_FFFF_FFFF) return a;
        return 64'($signed(a) / $signed(b));
      end
      3'b110: begin
        if (b == 0) return a;
        if (a == MinNeg && b == 64'hFFFF_FFFF_FFFF_FFFF) return 64'd0;
        return 64'($signed(a) % $signed(b));
      end
      default: return 64'd0;
    endcase
  endfunction

  // Issue one op, scramble inputs after acceptance, and check the fixed-latency result.
  // Sampling #1 after the 64th edge following acceptance observes what the 65th edge samples.
  task automatic run_op(input string name, input logic [2:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd);
    logic [63:0] exp;
    bit early;
    exp = ref_result(f, a, b);
    early = 0;
    @(negedge clk);
    op = f; ReadData1 = a; ReadData2 = b; RDIn = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ReadData1 = {$urandom, $urandom}; ReadData2 = {$urandom, $urandom};
    RDIn = 5'($urandom); op = 3'($urandom);
    checks++;
    if (Busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_accept: got %b want 1", name, Busy);
    end
    for (int i = 1; i < 64; i++) begin
      @(posedge clk); #1;
      if (RegWrite !== 1'b0 || Busy !== 1'b1) early = 1;
    end
    checks++;
    if (early) begin
      errors++; $display("FAIL %s early_strobe_or_busy_drop: got 1 want 0", name);
    end
    @(posedge clk); #1;
    checks++;
    if (RegWrite !== (rd != 0)) begin
      errors++; $display("FAIL %s regwrite: got %b want %b", name, RegWrite, rd != 0);
    end
    checks++;
    if (WriteData !== exp) begin
      errors++; $display("FAIL %s writedata: got %h want %h", name, WriteData, exp);
    end
    checks++;
    if (RD !== rd) begin
      errors++; $display("FAIL %s rd: got %0d want %0d", name, RD, rd);
    end
    @(posedge clk); #1;
    checks++;
    if (RegWrite !== 1'b0 || Busy !== 1'b0 || WriteData !== exp) begin
      errors++;
      $display("FAIL %s after_done: got rw=%b busy=%b wd=%h want rw=0 busy=0 wd=%h", name,
               RegWrite, Busy, WriteData, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (WriteData !== '0 || RD !== '0 || RegWrite !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got wd=%h rd=%0d rw=%b busy=%b want all 0",
               WriteData, RD, RegWrite, Busy);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_directed();
    run_op("mul_7x6", 3'b000, 64'd7, 64'd6, 5'd5);
    run_op("div_-20_3", 3'b100, -64'sd20, 64'd3, 5'd1);
    run_op("rem_-20_3", 3'b110, -64'sd20, 64'd3, 5'd2);
    run_op("divu_20_3", 3'b101, 64'd20, 64'd3, 5'd3);
    run_op("divu_by0", 3'b101, 64'd5, 64'd0, 5'd4);
    run_op("remu_by0", 3'b111, 64'd5, 64'd0, 5'd6);
    run_op("div_by0_neg", 3'b100, -64'sd9, 64'd0, 5'd7);
    run_op("rem_by0_neg", 3'b110, -64'sd9, 64'd0, 5'd8);
    run_op("div_ovf", 3'b100, MinNeg, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9);
    run_op("rem_ovf", 3'b110, MinNeg, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10);
  endtask

  task automatic test_random();
    logic [2:0] ops [5] = '{3'b000, 3'b100, 3'b101, 3'b110, 3'b111};
    logic [63:0] a, b;
    for (int n = 0; n < 16; n++) begin
      a = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: b = 64'($urandom_range(0, 20));
        1: b = -64'($urandom_range(1, 20));
        2: b = {32'd0, $urandom};
        default: b = {$urandom, $urandom};
      endcase
      run_op("random", ops[$urandom_range(0, 4)], a, b, 5'($urandom_range(1, 31)));
    end
  endtask

  task automatic test_ignore_busy();
    bit seen;
    int strobes;
    seen = 0; strobes = 0;
    @(negedge clk);
    op = 3'b000; ReadData1 = 64'd3; ReadData2 = 64'd4; RDIn = 5'd11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1; ReadData1 = 64'd9; ReadData2 = 64'd9;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (RegWrite === 1'b1) begin
        strobes++;
        if (!seen) begin
          seen = 1;
          checks++;
          if (WriteData !== 64'd12) begin
            errors++; $display("FAIL busy_ignore_result: got %0d want 12", WriteData);
          end
        end
      end
    end
    checks++;
    if (strobes != 1 || Busy !== 1'b0) begin
      errors++; $display("FAIL busy_ignore_strobes: got %0d want 1", strobes);
    end
  endtask

  task automatic test_reset_mid();
    bit strobe;
    strobe = 0;
    @(negedge clk);
    op = 3'b101; ReadData1 = 64'd1000; ReadData2 = 64'd7; RDIn = 5'd12; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (WriteData !== '0 || RD !== '0 || RegWrite !== 1'b0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: got wd=%h rd=%0d rw=%b busy=%b want all 0",
               WriteData, RD, RegWrite, Busy);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (RegWrite !== 1'b0 || Busy !== 1'b0) strobe = 1;
    end
    checks++;
    if (strobe) begin
      errors++; $display("FAIL reset_mid_no_strobe: got activity want none");
    end
    run_op("mul_after_reset", 3'b000, 64'd2, 64'd2, 5'd13);
  endtask

  task automatic test_rd_zero_and_bad_op();
    bit busy_seen;
    run_op("mul_rd0", 3'b000, 64'd3, 64'd3, 5'd0);
    busy_seen = 0;
    @(negedge clk);
    op = 3'b010; ReadData1 = 64'd8; ReadData2 = 64'd2; RDIn = 5'd14; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (Busy !== 1'b0 || RegWrite !== 1'b0) busy_seen = 1;
    end
    start = 1'b0;
    checks++;
    if (busy_seen) begin
      errors++; $display("FAIL unsupported_op: got busy/strobe want idle");
    end
  endtask

  // start held high: a second op is accepted XLEN+2 edges after the first.
  task automatic test_back_to_back();
    @(negedge clk);
    op = 3'b000; ReadData1 = 64'd11; ReadData2 = 64'd13; RDIn = 5'd15; start = 1'b1;
    @(posedge clk); #1;
    repeat (64) @(posedge clk);
    #1;
    checks++;
    if (RegWrite !== 1'b1 || WriteData !== 64'd143) begin
      errors++; $display("FAIL b2b_first: got rw=%b wd=%0d want rw=1 wd=143", RegWrite, WriteData);
    end
    op = 3'b101; ReadData1 = 64'd100; ReadData2 = 64'd7; RDIn = 5'd16;
    @(posedge clk); #1;
    checks++;
    if (Busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle_gap: got busy=%b want 0", Busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (Busy !== 1'b1) begin
      errors++; $display("FAIL b2b_second_accept: got busy=%b want 1", Busy);
    end
    repeat (64) @(posedge clk);
    #1;
    checks++;
    if (RegWrite !== 1'b1 || WriteData !== 64'd14 || RD !== 5'd16) begin
      errors++;
      $display("FAIL b2b_second: got rw=%b wd=%0d rd=%0d want rw=1 wd=14 rd=16",
               RegWrite, WriteData, RD);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_busy();
    test_reset_mid();
    test_rd_zero_and_bad_op();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
